dot_product_loader: RTL and testbench
=====================================

Name: dot_product_loader

Overview:
Host-side driver for the nibble-serial dot-product/running-max accumulator. Accepts a 16-bit weight vector and a 16-bit input vector, each holding four 4-bit lanes, through a valid/ready command port. It serializes each vector as four nibble beats with a weight/input select bit, waits for the accumulator to settle, then captures the accumulator's 10-bit running-max result and returns it on a valid/ready result port.

Parameters:
LANE_W, 4, bits per lane/nibble beat
LANES, 4, lanes per vector (beats per vector)
RES_W, 10, accumulator result width
SETTLE_CYCLES, 2, idle cycles between last input beat and result capture (0 allowed)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when both high
cmd_weights  in  16  weight lanes, lane0 = [3:0]
cmd_inputs  in  16  input lanes, lane0 = [3:0]
cmd_skip_w  in  1  reuse previously sent weights; send inputs only
nib_valid  out  1  nibble beat strobe (downstream shift enable)
nib_sel  out  1  1 = weight beat, 0 = input beat
nib_data  out  4  nibble payload
res_in  in  10  accumulator running-max result
res_valid  out  1  result available
res_ready  in  1  result consumed when both high
res_data  out  10  captured result
res_updated  out  1  captured result > previously captured result
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at rising edge, any state): state=IDLE; nib_valid=0, nib_sel=0, nib_data=0, res_valid=0, res_data=0, res_updated=0, busy=0; weights_loaded flag=0; beat/settle counters=0. Reset overrides every other event, including mid-transfer.
- States: IDLE, SEND_W, SEND_X, SETTLE, CAPTURE, DONE.
- IDLE: cmd_ready=1 (only state where it is 1). On accept, latch cmd_weights/cmd_inputs into shift registers and clear beat count. Go to SEND_X if cmd_skip_w=1 and weights_loaded=1, else SEND_W. cmd_skip_w with weights_loaded=0 is ignored and weights are sent.
- SEND_W: LANES cycles; nib_valid=1, nib_sel=1, nib_data=weight_sh[3:0]; shift right by LANE_W each cycle. Lane0 goes first. After the last beat, set weights_loaded=1 and go to SEND_X.
- SEND_X: same as SEND_W with nib_sel=0 and the input shift register. Then go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
- SETTLE: nib_valid=0 for SETTLE_CYCLES cycles, then CAPTURE.
- CAPTURE: one cycle. At its rising edge: res_data<=res_in; res_updated<=(res_in > previous res_data), unsigned compare. Go to DONE.
- DONE: res_valid=1. res_data and res_updated hold stable until res_ready=1, then go to IDLE and drop res_valid. No new command is accepted in DONE.
- Outside SEND_W/SEND_X: nib_valid=0, nib_data=0, nib_sel=0.
- Beat outputs are driven from registered state/shift registers and are glitch-free.
- Latency, with the accept edge in cycle 0:
  - Full transfer: beats in cycles 1..8; res_valid first high in cycle 10+SETTLE_CYCLES (12 at default).
  - Skip transfer: beats in cycles 1..4; res_valid in cycle 6+SETTLE_CYCLES.
- Throughput: with res_ready held at 1, the next command can be accepted in the cycle after DONE.
- cmd_* inputs are ignored outside IDLE. Changing cmd_* after acceptance does not affect the transfer in flight.

Test Plan:
- Reset, then cmd weights=0x4321, inputs=0x8765, skip=0 -> sel=1 beats 1,2,3,4; then sel=0 beats 5,6,7,8. With an accumulator model: res_valid in cycle 12, res_data=70 (5+12+21+32), res_updated=1.
- weights=0xFFFF, inputs=0xFFFF -> res_data=900 (0x384), full 10-bit width exercised.
- After the 0xFFFF case, send skip=1 with inputs=0x0001 -> no sel=1 beats; 4 input beats; res_valid in cycle 8; res_data=900 (accumulator holds its max); res_updated=0.
- Immediately after reset, send skip=1 -> weights are still sent (weights_loaded=0), giving 8 beats total.
- Hold res_ready=0 for 5 cycles in DONE -> res_valid, res_data and res_updated stay stable; cmd_ready=0 and busy=1 throughout; accept occurs on the cycle res_ready=1, then IDLE.
- Assert rst_n=0 during the 2nd input beat -> next cycle all outputs are at reset values and state is IDLE; the following command re-sends weights even if skip=1.

Source files
------------

// File: rtl/dot_product_loader.sv
// Host-side loader for the nibble-serial dot-product / running-max accumulator.
// Serializes a weight and an input vector as nibble beats, waits, then captures the result.
module dot_product_loader #(
    parameter int LANE_W        = 4,
    parameter int LANES         = 4,
    parameter int RES_W         = 10,
    parameter int SETTLE_CYCLES = 2,
    localparam int VEC_W        = LANE_W * LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [VEC_W-1:0]  cmd_weights,
    input  logic [VEC_W-1:0]  cmd_inputs,
    input  logic              cmd_skip_w,
    output logic              nib_valid,
    output logic              nib_sel,
    output logic [LANE_W-1:0] nib_data,
    input  logic [RES_W-1:0]  res_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_updated,
    output logic              busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_W  = 3'd1;
    localparam logic [2:0] S_SEND_X  = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST   = BW'(LANES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    logic [2:0]       state_q, state_d;
    logic [VEC_W-1:0] w_sh_q, w_sh_d;
    logic [VEC_W-1:0] x_sh_q, x_sh_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             loaded_q, loaded_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic             res_upd_q, res_upd_d;

    always_comb begin
        state_d    = state_q;
        w_sh_d     = w_sh_q;
        x_sh_d     = x_sh_q;
        beat_d     = beat_q;
        settle_d   = settle_q;
        loaded_d   = loaded_q;
        res_data_d = res_data_q;
        res_upd_d  = res_upd_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_sh_d  = cmd_weights;
                    x_sh_d  = cmd_inputs;
                    beat_d  = '0;
                    // Skipping is only honoured once the accumulator holds real weights.
                    state_d = (cmd_skip_w && loaded_q) ? S_SEND_X : S_SEND_W;
                end
            end
            S_SEND_W: begin
                w_sh_d = w_sh_q >> LANE_W;
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_LAST) begin
                    beat_d   = '0;
                    loaded_d = 1'b1;
                    state_d  = S_SEND_X;
                end
            end
            S_SEND_X: begin
                x_sh_d = x_sh_q >> LANE_W;
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_LAST) begin
                    beat_d   = '0;
                    settle_d = '0;
                    state_d  = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == SETTLE_LAST) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_data_d = res_in;
                res_upd_d  = (res_in > res_data_q);
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            w_sh_q     <= '0;
            x_sh_q     <= '0;
            beat_q     <= '0;
            settle_q   <= '0;
            loaded_q   <= 1'b0;
            res_data_q <= '0;
            res_upd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_sh_q     <= w_sh_d;
            x_sh_q     <= x_sh_d;
            beat_q     <= beat_d;
            settle_q   <= settle_d;
            loaded_q   <= loaded_d;
            res_data_q <= res_data_d;
            res_upd_q  <= res_upd_d;
        end
    end

    // Beat outputs decode only registered state, so they cannot glitch on cmd_* changes.
    always_comb begin
        nib_valid = (state_q == S_SEND_W) || (state_q == S_SEND_X);
        nib_sel   = (state_q == S_SEND_W);
        nib_data  = '0;
        if (state_q == S_SEND_W)      nib_data = w_sh_q[LANE_W-1:0];
        else if (state_q == S_SEND_X) nib_data = x_sh_q[LANE_W-1:0];
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign res_data    = res_data_q;
    assign res_updated = res_upd_q;

endmodule

// File: tb/tb_dot_product_loader.sv
// Scoreboard bench for dot_product_loader with a behavioural accumulator on the nibble bus.
module tb_dot_product_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_skip_w;
    logic [15:0] cmd_weights, cmd_inputs;
    logic        nib_valid, nib_sel;
    logic [3:0]  nib_data;
    logic [9:0]  res_in;
    logic        res_valid, res_ready, res_updated, busy;
    logic [9:0]  res_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_c = 0;

    typedef struct { logic sel; logic [3:0] data; } beat_t;
    typedef struct { logic [9:0] data; logic upd; int lat; } res_t;
    beat_t exp_beats[$];
    res_t  exp_res[$];

    dot_product_loader dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_weights(cmd_weights), .cmd_inputs(cmd_inputs), .cmd_skip_w(cmd_skip_w),
        .nib_valid(nib_valid), .nib_sel(nib_sel), .nib_data(nib_data),
        .res_in(res_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_updated(res_updated), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event want none (cycle %0d)", name, cyc);
    endtask

    // Accumulator stand-in: shifts nibbles in, and on every 4th input beat folds the
    // new dot product into a running maximum that drives res_in.
    function automatic logic [9:0] dotf(input logic [15:0] w, input logic [15:0] x);
        logic [9:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s = s + 10'(w[i*4 +: 4]) * 10'(x[i*4 +: 4]);
        return s;
    endfunction

    logic [15:0] mw, mx;
    logic [1:0]  mcnt;
    logic [9:0]  mmax;
    assign res_in = mmax;

    always @(posedge clk) begin
        if (!rst_n) begin
            mw <= '0; mx <= '0; mcnt <= '0; mmax <= '0;
        end else if (nib_valid) begin
            if (nib_sel) mw <= {nib_data, mw[15:4]};
            else begin
                mx   <= {nib_data, mx[15:4]};
                mcnt <= mcnt + 2'd1;
                if (mcnt == 2'd3 && dotf(mw, {nib_data, mx[15:4]}) > mmax)
                    mmax <= dotf(mw, {nib_data, mx[15:4]});
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a beat or a result.
    logic seen = 1'b0;
    always @(negedge clk) begin
        beat_t b;
        res_t  r;
        if (nib_valid === 1'b1) begin
            if (exp_beats.size() == 0) fail_now("beat_extra");
            else begin
                b = exp_beats.pop_front();
                chk("beat_sel", int'(nib_sel), int'(b.sel));
                chk("beat_data", int'(nib_data), int'(b.data));
            end
        end
        if (res_valid === 1'b1 && !seen) begin
            seen = 1'b1;
            if (exp_res.size() == 0) fail_now("res_extra");
            else chk("res_latency", cyc - acc_c, exp_res[0].lat);
        end
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            seen = 1'b0;
            if (exp_res.size() != 0) begin
                r = exp_res.pop_front();
                chk("res_data", int'(res_data), int'(r.data));
                chk("res_updated", int'(res_updated), int'(r.upd));
            end
        end
    end

    task automatic send(input logic [15:0] w, input logic [15:0] x, input logic skip,
                        input logic send_w, input logic push_res,
                        input logic [9:0] r, input logic u, input int lat);
        beat_t b;
        res_t  e;
        bit    ok;
        if (send_w) for (int i = 0; i < 4; i++) begin
            b.sel = 1'b1; b.data = w[i*4 +: 4]; exp_beats.push_back(b);
        end
        for (int i = 0; i < 4; i++) begin
            b.sel = 1'b0; b.data = x[i*4 +: 4]; exp_beats.push_back(b);
        end
        if (push_res) begin
            e.data = r; e.upd = u; e.lat = lat; exp_res.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_weights = w; cmd_inputs = x; cmd_skip_w = skip;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) fail_now("accept_timeout");
        acc_c = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_weights = 16'h5A5A; cmd_inputs = 16'hA5A5; cmd_skip_w = ~skip;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (exp_res.size() == 0 && exp_beats.size() == 0) ok = 1'b1;
        end
        if (!ok) fail_now("done_timeout");
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_nib_valid"}, int'(nib_valid), 0);
        chk({tag, "_nib_sel"}, int'(nib_sel), 0);
        chk({tag, "_nib_data"}, int'(nib_data), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_data"}, int'(res_data), 0);
        chk({tag, "_res_updated"}, int'(res_updated), 0);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_skip_w = 1'b0; res_ready = 1'b1;
        cmd_weights = '0; cmd_inputs = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("reset");

        // 1*5 + 2*6 + 3*7 + 4*8 = 70
        send(16'h4321, 16'h8765, 1'b0, 1'b1, 1'b1, 10'd70, 1'b1, 12);
        wait_done();
        // 4 * 15 * 15 = 900
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 10'd900, 1'b1, 12);
        wait_done();

        // Skip with loaded weights; dot = 15 so the max stays 900. Hold the result 5 cycles.
        res_ready = 1'b0;
        send(16'h1111, 16'h0001, 1'b1, 1'b0, 1'b1, 10'd900, 1'b0, 8);
        cmd_valid = 1'b1; cmd_weights = 16'hAAAA; cmd_inputs = 16'hAAAA; cmd_skip_w = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (res_valid === 1'b1) ok = 1'b1;
        end
        if (!ok) fail_now("hold_res_timeout");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_res_data", int'(res_data), 900);
            chk("hold_res_updated", int'(res_updated), 0);
            chk("hold_cmd_ready", int'(cmd_ready), 0);
            chk("hold_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_hold_cmd_ready", int'(cmd_ready), 1);
        chk("post_hold_busy", int'(busy), 0);
        chk("post_hold_res_valid", int'(res_valid), 0);

        // Reset during the 2nd input beat (cycle 6 after accept).
        send(16'h2222, 16'h3333, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_beats.delete();
        @(negedge clk);
        chk_reset_outs("midreset");

        // Weights not loaded after reset, so skip is ignored: 4 * 1 * 2 = 8.
        send(16'h1111, 16'h2222, 1'b1, 1'b1, 1'b1, 10'd8, 1'b1, 12);
        wait_done();

        repeat (3) @(negedge clk);
        chk("left_beats", exp_beats.size(), 0);
        chk("left_results", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
